// File: rtl/gate_array_pipe.sv
// Multi-channel bitwise gate array with a run-time selectable function.
// The result travels through a LATENCY-deep valid/ready pipeline with collapsing bubbles.
module gate_array_pipe #(
    parameter int         CHANNELS   = 4,
    parameter int         WIDTH      = 1,
    parameter int         LATENCY    = 2,
    parameter logic [2:0] DEFAULT_OP = 3'd0
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      op_load,
    input  logic [2:0]                op_sel,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [CHANNELS*WIDTH-1:0] a,
    input  logic [CHANNELS*WIDTH-1:0] b,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [CHANNELS*WIDTH-1:0] y,
    output logic [2:0]                op_cur,
    output logic [15:0]               xfer_cnt
);

    localparam int DW = CHANNELS * WIDTH;

    localparam logic [2:0] OP_NAND = 3'd0;
    localparam logic [2:0] OP_AND  = 3'd1;
    localparam logic [2:0] OP_OR   = 3'd2;
    localparam logic [2:0] OP_NOR  = 3'd3;
    localparam logic [2:0] OP_XOR  = 3'd4;
    localparam logic [2:0] OP_XNOR = 3'd5;
    localparam logic [2:0] OP_NOTA = 3'd6;

    // Channels are independent and bitwise, so the whole packed vector is evaluated at once.
    function automatic logic [DW-1:0] gate_fn(input logic [2:0] op,
                                              input logic [DW-1:0] x,
                                              input logic [DW-1:0] z);
        case (op)
            OP_NAND: gate_fn = ~(x & z);
            OP_AND:  gate_fn = x & z;
            OP_OR:   gate_fn = x | z;
            OP_NOR:  gate_fn = ~(x | z);
            OP_XOR:  gate_fn = x ^ z;
            OP_XNOR: gate_fn = ~(x ^ z);
            OP_NOTA: gate_fn = ~x;
            default: gate_fn = x;
        endcase
    endfunction

    logic [2:0]         op_q, op_d;
    logic [15:0]        xfer_q, xfer_d;
    logic [LATENCY-1:0] vld_q;
    logic [LATENCY-1:0] adv;
    logic [DW-1:0]      data_q [LATENCY];
    logic               accept;
    logic               xfer;

    // A stage advances when the consumer takes the head or some stage at/after it is empty.
    always_comb begin
        logic tail_full;
        tail_full = 1'b1;
        adv       = '0;
        for (int i = LATENCY - 1; i >= 0; i--) begin
            tail_full = tail_full & vld_q[i];
            adv[i]    = out_ready | ~tail_full;
        end
    end

    assign in_ready  = ~rst & adv[0];
    assign accept    = in_valid & in_ready;
    assign out_valid = vld_q[LATENCY-1];
    assign xfer      = out_valid & out_ready;
    assign y         = out_valid ? data_q[LATENCY-1] : '0;
    assign op_cur    = op_q;
    assign xfer_cnt  = xfer_q;

    always_comb begin
        op_d   = op_load ? op_sel : op_q;
        xfer_d = (xfer && xfer_q != 16'hFFFF) ? xfer_q + 16'd1 : xfer_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            op_q   <= DEFAULT_OP;
            xfer_q <= '0;
            vld_q  <= '0;
        end else begin
            op_q   <= op_d;
            xfer_q <= xfer_d;
            if (adv[0])
                vld_q[0] <= accept;
            for (int i = 1; i < LATENCY; i++)
                if (adv[i])
                    vld_q[i] <= vld_q[i-1];
        end
    end

    // Stage boundary registers; payload is qualified by vld_q so it carries no reset.
    always_ff @(posedge clk) begin
        if (adv[0] && accept)
            data_q[0] <= gate_fn(op_q, a, b);
        for (int i = 1; i < LATENCY; i++)
            if (adv[i] && vld_q[i-1])
                data_q[i] <= data_q[i-1];
    end

endmodule

// File: tb/tb_gate_array_pipe.sv
// Directed and randomised checks of gate_array_pipe in two configurations.
module tb_gate_array_pipe;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    // Instance A: CHANNELS=4, WIDTH=1, LATENCY=2
    logic        a_op_load, a_in_valid, a_in_ready, a_out_valid, a_out_ready;
    logic [2:0]  a_op_sel, a_op_cur;
    logic [3:0]  a_a, a_b, a_y;
    logic [15:0] a_xfer_cnt;

    // Instance B: CHANNELS=4, WIDTH=8, LATENCY=3
    logic        b_op_load, b_in_valid, b_in_ready, b_out_valid, b_out_ready;
    logic [2:0]  b_op_sel, b_op_cur;
    logic [31:0] b_a, b_b, b_y;
    logic [15:0] b_xfer_cnt;

    gate_array_pipe #(.CHANNELS(4), .WIDTH(1), .LATENCY(2), .DEFAULT_OP(3'd0)) dut_a (
        .clk(clk), .rst(rst), .op_load(a_op_load), .op_sel(a_op_sel),
        .in_valid(a_in_valid), .in_ready(a_in_ready), .a(a_a), .b(a_b),
        .out_valid(a_out_valid), .out_ready(a_out_ready), .y(a_y),
        .op_cur(a_op_cur), .xfer_cnt(a_xfer_cnt)
    );

    gate_array_pipe #(.CHANNELS(4), .WIDTH(8), .LATENCY(3), .DEFAULT_OP(3'd0)) dut_b (
        .clk(clk), .rst(rst), .op_load(b_op_load), .op_sel(b_op_sel),
        .in_valid(b_in_valid), .in_ready(b_in_ready), .a(b_a), .b(b_b),
        .out_valid(b_out_valid), .out_ready(b_out_ready), .y(b_y),
        .op_cur(b_op_cur), .xfer_cnt(b_xfer_cnt)
    );

    int n_cmp = 0;
    int n_bad = 0;

    // Truth-table reference: bit {a,b} of the table gives the output for that input pair.
    function automatic logic [31:0] ref_gate(input logic [2:0] op, input logic [31:0] x, input logic [31:0] z);
        logic [3:0] tt;
        logic [31:0] r;
        case (op)
            3'd0: tt = 4'b0111;
            3'd1: tt = 4'b1000;
            3'd2: tt = 4'b1110;
            3'd3: tt = 4'b0001;
            3'd4: tt = 4'b0110;
            3'd5: tt = 4'b1001;
            3'd6: tt = 4'b0011;
            default: tt = 4'b1100;
        endcase
        for (int i = 0; i < 32; i++) r[i] = tt[{x[i], z[i]}];
        return r;
    endfunction

    task automatic test_reset;
        rst = 1'b1;
        a_op_load = 0; a_op_sel = 0; a_in_valid = 0; a_a = 0; a_b = 0; a_out_ready = 1;
        b_op_load = 0; b_op_sel = 0; b_in_valid = 0; b_a = 0; b_b = 0; b_out_ready = 1;
        @(negedge clk); #1;
        n_cmp++; if (a_in_ready !== 1'b0) begin n_bad++; $display("FAIL rst_in_ready_a: got %b want 0", a_in_ready); end
        n_cmp++; if (b_in_ready !== 1'b0) begin n_bad++; $display("FAIL rst_in_ready_b: got %b want 0", b_in_ready); end
        @(posedge clk); @(negedge clk);
        n_cmp++; if ({a_out_valid, a_y, a_op_cur, a_xfer_cnt} !== {1'b0, 4'h0, 3'd0, 16'h0}) begin
            n_bad++; $display("FAIL rst_state_a: got v=%b y=%h op=%0d cnt=%0d want 0/0/0/0", a_out_valid, a_y, a_op_cur, a_xfer_cnt); end
        n_cmp++; if ({b_out_valid, b_y, b_op_cur, b_xfer_cnt} !== {1'b0, 32'h0, 3'd0, 16'h0}) begin
            n_bad++; $display("FAIL rst_state_b: got v=%b y=%h op=%0d cnt=%0d want 0/0/0/0", b_out_valid, b_y, b_op_cur, b_xfer_cnt); end
        rst = 1'b0; #1;
        n_cmp++; if (a_in_ready !== 1'b1) begin n_bad++; $display("FAIL post_rst_in_ready: got %b want 1", a_in_ready); end
    endtask

    task automatic test_nand_latency;
        a_in_valid = 1; a_a = 4'b1100; a_b = 4'b1010; #1;
        n_cmp++; if (a_in_ready !== 1'b1) begin n_bad++; $display("FAIL nand_accept: in_ready got %b want 1", a_in_ready); end
        @(posedge clk); @(negedge clk);
        a_in_valid = 0; #1;
        n_cmp++; if (a_out_valid !== 1'b0) begin n_bad++; $display("FAIL nand_early: out_valid got %b want 0", a_out_valid); end
        @(posedge clk); @(negedge clk); #1;
        n_cmp++; if ({a_out_valid, a_y} !== {1'b1, 4'b0111}) begin
            n_bad++; $display("FAIL nand_result: got v=%b y=%b want v=1 y=0111", a_out_valid, a_y); end
        @(posedge clk); @(negedge clk); #1;
        n_cmp++; if ({a_out_valid, a_xfer_cnt} !== {1'b0, 16'd1}) begin
            n_bad++; $display("FAIL nand_drain: got v=%b cnt=%0d want v=0 cnt=1", a_out_valid, a_xfer_cnt); end
    endtask

    task automatic test_back_to_back;
        logic [3:0] exp_y [4];
        exp_y[0] = 4'hF; exp_y[1] = 4'hE; exp_y[2] = 4'hD; exp_y[3] = 4'hC;
        a_b = 4'hF;
        for (int i = 0; i < 6; i++) begin
            a_in_valid = (i < 4);
            a_a = 4'(i);
            #1;
            if (i < 4) begin
                n_cmp++; if (a_in_ready !== 1'b1) begin n_bad++; $display("FAIL b2b_ready[%0d]: got %b want 1", i, a_in_ready); end
            end
            if (i >= 2) begin
                n_cmp++; if ({a_out_valid, a_y} !== {1'b1, exp_y[i-2]}) begin
                    n_bad++; $display("FAIL b2b_y[%0d]: got v=%b y=%h want v=1 y=%h", i, a_out_valid, a_y, exp_y[i-2]); end
            end
            @(posedge clk); @(negedge clk);
        end
        a_in_valid = 0; #1;
        n_cmp++; if (a_xfer_cnt !== 16'd5) begin n_bad++; $display("FAIL b2b_cnt: got %0d want 5", a_xfer_cnt); end
    endtask

    task automatic test_op_load;
        a_op_load = 1; a_op_sel = 3'd2; a_in_valid = 1; a_a = 4'h0; a_b = 4'hF;
        @(posedge clk); @(negedge clk);
        a_op_load = 0; #1;
        n_cmp++; if (a_op_cur !== 3'd2) begin n_bad++; $display("FAIL opload_cur: got %0d want 2", a_op_cur); end
        @(posedge clk); @(negedge clk);
        a_a = 4'h0; a_b = 4'h0; #1;
        n_cmp++; if ({a_out_valid, a_y} !== {1'b1, 4'hF}) begin
            n_bad++; $display("FAIL opload_same_cycle_nand: got v=%b y=%h want v=1 y=f", a_out_valid, a_y); end
        @(posedge clk); @(negedge clk);
        a_in_valid = 0; #1;
        n_cmp++; if ({a_out_valid, a_y} !== {1'b1, 4'hF}) begin
            n_bad++; $display("FAIL opload_or_01: got v=%b y=%h want v=1 y=f", a_out_valid, a_y); end
        @(posedge clk); @(negedge clk); #1;
        n_cmp++; if ({a_out_valid, a_y} !== {1'b1, 4'h0}) begin
            n_bad++; $display("FAIL opload_or_00: got v=%b y=%h want v=1 y=0", a_out_valid, a_y); end
        @(posedge clk); @(negedge clk);
    endtask

    task automatic test_op_sweep;
        logic [7:0] exp_b [8];
        logic [7:0] e;
        int waited;
        exp_b[0] = 8'h3F; exp_b[1] = 8'hC0; exp_b[2] = 8'hFC; exp_b[3] = 8'h03;
        exp_b[4] = 8'h3C; exp_b[5] = 8'hC3; exp_b[6] = 8'h0F; exp_b[7] = 8'hF0;
        b_out_ready = 1;
        for (int k = 0; k < 8; k++) begin
            b_op_load = 1; b_op_sel = 3'(k); b_in_valid = 0;
            @(posedge clk); @(negedge clk);
            b_op_load = 0; b_in_valid = 1; b_a = {4{8'hF0}}; b_b = {4{8'hCC}}; #1;
            n_cmp++; if ({b_op_cur, b_in_ready} !== {3'(k), 1'b1}) begin
                n_bad++; $display("FAIL sweep_op[%0d]: got op=%0d rdy=%b want op=%0d rdy=1", k, b_op_cur, b_in_ready, k); end
            @(posedge clk); @(negedge clk);
            b_in_valid = 0; #1;
            waited = 0;
            while (!b_out_valid && waited < 8) begin
                @(posedge clk); @(negedge clk); #1; waited++;
            end
            e = exp_b[k];
            n_cmp++; if ({b_out_valid, b_y} !== {1'b1, {4{e}}} || waited != 2) begin
                n_bad++; $display("FAIL sweep_y[%0d]: got v=%b y=%h after %0d cycles want v=1 y=%h after 2", k, b_out_valid, b_y, waited, {4{e}}); end
            @(posedge clk); @(negedge clk);
        end
    endtask

    task automatic test_backpressure;
        logic [31:0] samp [5];
        for (int i = 0; i < 5; i++) samp[i] = 32'h11111111 * (i + 1);
        b_out_ready = 0; b_in_valid = 1; b_b = 32'h0;
        for (int i = 0; i < 5; i++) begin
            b_a = samp[i]; #1;
            n_cmp++; if (b_in_ready !== (i < 3)) begin
                n_bad++; $display("FAIL bp_ready[%0d]: got %b want %b", i, b_in_ready, (i < 3)); end
            @(posedge clk); @(negedge clk);
        end
        b_in_valid = 0;
        for (int j = 0; j < 2; j++) begin
            #1;
            n_cmp++; if ({b_out_valid, b_y} !== {1'b1, samp[0]}) begin
                n_bad++; $display("FAIL bp_hold[%0d]: got v=%b y=%h want v=1 y=%h", j, b_out_valid, b_y, samp[0]); end
            @(posedge clk); @(negedge clk);
        end
        b_out_ready = 1;
        for (int j = 0; j < 3; j++) begin
            #1;
            n_cmp++; if ({b_out_valid, b_y} !== {1'b1, samp[j]}) begin
                n_bad++; $display("FAIL bp_drain[%0d]: got v=%b y=%h want v=1 y=%h", j, b_out_valid, b_y, samp[j]); end
            @(posedge clk); @(negedge clk);
        end
        #1;
        n_cmp++; if ({b_out_valid, b_in_ready, b_xfer_cnt} !== {1'b0, 1'b1, 16'd11}) begin
            n_bad++; $display("FAIL bp_end: got v=%b rdy=%b cnt=%0d want v=0 rdy=1 cnt=11", b_out_valid, b_in_ready, b_xfer_cnt); end
    endtask

    task automatic test_reset_inflight;
        int stale;
        b_out_ready = 0; b_in_valid = 1; b_a = 32'hA5A5A5A5;
        @(posedge clk); @(negedge clk);
        b_a = 32'h5A5A5A5A;
        @(posedge clk); @(negedge clk);
        b_in_valid = 0; rst = 1; #1;
        n_cmp++; if (b_in_ready !== 1'b0) begin n_bad++; $display("FAIL rstf_in_ready: got %b want 0", b_in_ready); end
        @(posedge clk); @(negedge clk);
        rst = 0; #1;
        n_cmp++; if ({b_out_valid, b_y, b_op_cur, b_xfer_cnt} !== {1'b0, 32'h0, 3'd0, 16'h0}) begin
            n_bad++; $display("FAIL rstf_state: got v=%b y=%h op=%0d cnt=%0d want 0/0/0/0", b_out_valid, b_y, b_op_cur, b_xfer_cnt); end
        b_out_ready = 1;
        stale = 0;
        for (int j = 0; j < 6; j++) begin
            @(posedge clk); @(negedge clk); #1;
            if (b_out_valid) stale++;
        end
        n_cmp++; if (stale != 0 || b_xfer_cnt !== 16'h0) begin
            n_bad++; $display("FAIL rstf_stale: got %0d stale outputs cnt=%0d want 0 and 0", stale, b_xfer_cnt); end
    endtask

    task automatic test_random;
        logic [31:0] q [$];
        logic [31:0] exp_y;
        logic [2:0]  model_op;
        int accepted, cycles, bad_before;
        model_op = 3'd0; accepted = 0; cycles = 0;
        bad_before = n_bad;
        while ((accepted < 70000 || q.size() != 0) && cycles < 95000) begin
            b_in_valid  = (accepted < 70000) && ($urandom_range(31) != 0);
            b_a         = $urandom;
            b_b         = $urandom;
            b_out_ready = (accepted >= 70000) || ($urandom_range(31) != 0);
            b_op_load   = ($urandom_range(15) == 0);
            b_op_sel    = 3'($urandom_range(7));
            #1;
            if (b_out_valid && b_out_ready) begin
                n_cmp++;
                if (q.size() == 0) begin
                    n_bad++; $display("FAIL rand_extra: got unexpected y=%h want no output", b_y);
                end else begin
                    exp_y = q.pop_front();
                    if (b_y !== exp_y) begin
                        n_bad++;
                        if (n_bad - bad_before < 10) $display("FAIL rand_y: got %h want %h", b_y, exp_y);
                    end
                end
            end
            if (b_in_valid && b_in_ready) begin
                q.push_back(ref_gate(model_op, b_a, b_b));
                accepted++;
            end
            if (b_op_load) model_op = b_op_sel;
            @(posedge clk); @(negedge clk);
            cycles++;
        end
        b_in_valid = 0; b_op_load = 0; #1;
        n_cmp++; if (q.size() != 0 || accepted != 70000) begin
            n_bad++; $display("FAIL rand_timeout: got %0d accepted %0d pending want 70000 and 0", accepted, q.size()); end
        n_cmp++; if (b_xfer_cnt !== 16'hFFFF) begin
            n_bad++; $display("FAIL rand_cnt_sat: got %h want ffff", b_xfer_cnt); end
    endtask

    initial begin
        test_reset();
        test_nand_latency();
        test_back_to_back();
        test_op_load();
        test_op_sweep();
        test_backpressure();
        test_reset_inflight();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
